// File: rtl/qenc_pkg.sv
// Shared definitions for the quadrature encoder / pushbutton emulator:
// command op codes, FSM state encodings and the {B,A} Gray stepping table.
package qenc_pkg;

  // Command op codes carried on cmd_op
  typedef enum logic [1:0] {
    OP_CW    = 2'b00,
    OP_CCW   = 2'b01,
    OP_SHORT = 2'b10,
    OP_LONG  = 2'b11
  } qenc_op_e;

  // Emulator FSM states; SETTLE is the post-release hold after a press
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ROTATE = 2'd1,
    ST_PRESS  = 2'd2,
    ST_SETTLE = 2'd3
  } qenc_state_e;

  // Idle / reset levels of the emulated lines
  localparam logic [1:0] ENC_RST = 2'b00;
  localparam logic       PB_RST  = 1'b1;

  // Next {B,A} state in the clockwise direction: 00->01->11->10->00
  function automatic logic [1:0] gray_next(input logic [1:0] ba);
    logic [1:0] nxt;
    case (ba)
      2'b00:   nxt = 2'b01;
      2'b01:   nxt = 2'b11;
      2'b11:   nxt = 2'b10;
      default: nxt = 2'b00;
    endcase
    return nxt;
  endfunction

  // Previous {B,A} state, i.e. one counter-clockwise transition
  function automatic logic [1:0] gray_prev(input logic [1:0] ba);
    logic [1:0] prv;
    case (ba)
      2'b00:   prv = 2'b10;
      2'b10:   prv = 2'b11;
      2'b11:   prv = 2'b01;
      default: prv = 2'b00;
    endcase
    return prv;
  endfunction

  // Largest of three values, used to size the shared dwell counter
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return m;
  endfunction

endpackage

// File: rtl/qenc_bounce_lfsr.sv
// Contact-bounce generator for the emulated lines (built only with
// QENC_BOUNCE_EN). Every edge of a nominal line opens a window of
// BOUNCE_CYCLES cycles in which the output shows either the old or the new
// level, picked by lfsr[0]; afterwards the output follows the nominal level.
module qenc_bounce_lfsr
  import qenc_pkg::*;
#(
  parameter int         N             = 3,
  parameter int         BOUNCE_CYCLES = 2,
  parameter logic [N-1:0] RST_VAL     = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] line_nom_i,
  output logic [N-1:0] line_o
);

  localparam int WIN_W = (BOUNCE_CYCLES > 1) ? $clog2(BOUNCE_CYCLES + 1) : 1;

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  // LFSR x^8+x^6+x^5+x^4+1, shifting left every cycle
  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  // LFSR register, reseeded on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= 8'hA5;
    else        lfsr_q <= lfsr_d;
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_line
    logic             prev_q;
    logic             prev_d;
    logic [WIN_W-1:0] win_q;
    logic [WIN_W-1:0] win_d;
    logic             edge_now;
    logic             active;

    // Detect a nominal edge and track the remaining bounce window
    always_comb begin
      edge_now = (line_nom_i[gi] != prev_q);
      active   = edge_now || (win_q != '0);
      prev_d   = line_nom_i[gi];
      win_d    = '0;
      if (edge_now)          win_d = WIN_W'(BOUNCE_CYCLES - 1);
      else if (win_q != '0)  win_d = win_q - WIN_W'(1);
    end

    // Per-line history and window counter
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        prev_q <= RST_VAL[gi];
        win_q  <= '0;
      end else begin
        prev_q <= prev_d;
        win_q  <= win_d;
      end
    end

    // Inside the window an inverted line is the old level of a 1-bit edge
    assign line_o[gi] = (active && lfsr_q[0]) ? ~line_nom_i[gi] : line_nom_i[gi];
  end

endmodule

// File: rtl/quad_enc_emulator.sv
// Command-driven quadrature encoder and pushbutton emulator.
// Accepts rotate / press commands on a valid-ready handshake and drives
// Gray-coded {B,A} channels, an active-low pushbutton and a net position.
// Optional contact bounce on every line edge: define QENC_BOUNCE_EN.
module quad_enc_emulator
  import qenc_pkg::*;
#(
  parameter int STEP_CYCLES   = 4,
  parameter int SHORT_CYCLES  = 8,
  parameter int LONG_CYCLES   = 32,
  parameter int CNT_W         = 8,
  parameter int BOUNCE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  output logic [1:0]       enc_o,
  output logic             pb_n,
  output logic             done,
  output logic [15:0]      pos
);

  localparam int DWELL_MAX = max3(STEP_CYCLES, SHORT_CYCLES, LONG_CYCLES);
  localparam int DWELL_W   = $clog2(DWELL_MAX + 1);

  if (STEP_CYCLES < 2 || BOUNCE_CYCLES >= STEP_CYCLES || BOUNCE_CYCLES < 1) begin : g_bad_param
    $error("quad_enc_emulator: need STEP_CYCLES>=2 and 1<=BOUNCE_CYCLES<STEP_CYCLES");
  end

  qenc_state_e        state_q, state_d;
  logic [1:0]         enc_q, enc_d;
  logic               pb_q, pb_d;
  logic               done_q, done_d;
  logic [15:0]        pos_q, pos_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [CNT_W-1:0]   steps_q, steps_d;
  logic               ccw_q, ccw_d;
  qenc_op_e           op;

  assign op        = qenc_op_e'(cmd_op);
  assign cmd_ready = (state_q == ST_IDLE);
  assign done      = done_q;
  assign pos       = pos_q;

  // Next-state logic: accept commands in IDLE, pace transitions and presses
  always_comb begin
    state_d = state_q;
    enc_d   = enc_q;
    pb_d    = pb_q;
    done_d  = 1'b0;
    pos_d   = pos_q;
    dwell_d = dwell_q;
    steps_d = steps_q;
    ccw_d   = ccw_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          case (op)
            OP_CW, OP_CCW: begin
              if (cmd_count == '0) begin
                // Nothing to move: complete immediately without an edge
                done_d = 1'b1;
              end else begin
                // First transition is registered at the accept edge
                ccw_d   = (op == OP_CCW);
                enc_d   = (op == OP_CCW) ? gray_prev(enc_q) : gray_next(enc_q);
                pos_d   = (op == OP_CCW) ? pos_q - 16'd1 : pos_q + 16'd1;
                steps_d = cmd_count - CNT_W'(1);
                dwell_d = DWELL_W'(STEP_CYCLES - 1);
                state_d = ST_ROTATE;
              end
            end
            default: begin
              pb_d    = 1'b0;
              dwell_d = (op == OP_LONG) ? DWELL_W'(LONG_CYCLES - 1)
                                        : DWELL_W'(SHORT_CYCLES - 1);
              state_d = ST_PRESS;
            end
          endcase
        end
      end
      ST_ROTATE: begin
        if (dwell_q != '0) begin
          dwell_d = dwell_q - DWELL_W'(1);
        end else if (steps_q != '0) begin
          enc_d   = ccw_q ? gray_prev(enc_q) : gray_next(enc_q);
          pos_d   = ccw_q ? pos_q - 16'd1 : pos_q + 16'd1;
          steps_d = steps_q - CNT_W'(1);
          dwell_d = DWELL_W'(STEP_CYCLES - 1);
        end else begin
          // Last state has been held a full step
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      ST_PRESS: begin
        if (dwell_q != '0) begin
          dwell_d = dwell_q - DWELL_W'(1);
        end else begin
          pb_d    = 1'b1;
          dwell_d = DWELL_W'(STEP_CYCLES - 1);
          state_d = ST_SETTLE;
        end
      end
      default: begin
        if (dwell_q != '0) begin
          dwell_d = dwell_q - DWELL_W'(1);
        end else begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
    endcase
  end

  // State, line and counter registers; reset aborts any command at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      enc_q   <= ENC_RST;
      pb_q    <= PB_RST;
      done_q  <= 1'b0;
      pos_q   <= '0;
      dwell_q <= '0;
      steps_q <= '0;
      ccw_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      enc_q   <= enc_d;
      pb_q    <= pb_d;
      done_q  <= done_d;
      pos_q   <= pos_d;
      dwell_q <= dwell_d;
      steps_q <= steps_d;
      ccw_q   <= ccw_d;
    end
  end

`ifdef QENC_BOUNCE_EN
  logic [2:0] line_out;

  qenc_bounce_lfsr #(
    .N             (3),
    .BOUNCE_CYCLES (BOUNCE_CYCLES),
    .RST_VAL       ({PB_RST, ENC_RST})
  ) u_bounce (
    .clk        (clk),
    .rst_n      (rst_n),
    .line_nom_i ({pb_q, enc_q}),
    .line_o     (line_out)
  );

  assign enc_o = line_out[1:0];
  assign pb_n  = line_out[2];
`else
  assign enc_o = enc_q;
  assign pb_n  = pb_q;
`endif

endmodule
